lru_state_array: RTL and testbench

- Per-set storage for the 3-way cache replacement state: a 9-bit pairwise-order LRU vector and 3 way-valid bits per set.
- Feeds the PLRU update logic. A set is read in one cycle, the PLRU logic computes o_lru / isevict / lru_way, and the controller writes the updated state back here.
- On reset, and on flush, a sequential walker reinitialises every set before accesses are accepted.
- Same-set read-after-write hazards between back-to-back accesses are resolved by forwarding.

---
 rtl/lru_pkg.sv | 35 +++
 rtl/lru_ram.sv | 29 ++
 rtl/lru_state_array.sv | 170 +++++++++++++++++
 tb/tb_lru_state_array.sv | 535 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lru_pkg.sv
// lru_pkg: shared widths, init values, FSM encoding and entry layout for the
// 3-way LRU state array. Optional feature macro: LRU_PARITY_EN (adds one
// even-parity bit per stored entry).
package lru_pkg;

  localparam int LRU_W = 9;
  localparam int VLD_W = 3;

  localparam logic [LRU_W-1:0] LRU_INIT = 9'h000;
  localparam logic [VLD_W-1:0] VLD_INIT = 3'b000;

  // FSM encoding kept as plain constants so older tools can consume it.
  localparam logic [0:0] INIT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

`ifdef LRU_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif

  // Stored entry: {[parity,] vld, lru}; lru sits in the low bits.
  localparam int ENTRY_W = LRU_W + VLD_W + PAR_W;

  typedef struct packed {
    logic [VLD_W-1:0] vld;
    logic [LRU_W-1:0] lru;
  } lru_entry_t;

  // Even parity bit: chosen so the XOR over {parity, vld, lru} is zero.
  function automatic logic lru_parity(input lru_entry_t ent);
    return ^ent;
  endfunction

endpackage

// File: rtl/lru_ram.sv
// lru_ram: NUM_SETS x ENTRY_W storage with one synchronous write port and
// one combinational read port; the parent registers the read data.
// Entry width grows by one bit when LRU_PARITY_EN is defined.
module lru_ram
  import lru_pkg::*;
#(
  parameter int NUM_SETS = 32,
  parameter int SET_W    = 5
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [SET_W-1:0]   waddr_i,
  input  logic [ENTRY_W-1:0] wdata_i,
  input  logic [SET_W-1:0]   raddr_i,
  output logic [ENTRY_W-1:0] rdata_o
);

  logic [ENTRY_W-1:0] mem_q [NUM_SETS];

  // Write port: contents have no reset; the parent's init walk clears them.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/lru_state_array.sv
// lru_state_array: per-set 3-way replacement state (9-bit pairwise LRU vector
// plus 3 way-valid bits). A walker clears every set after reset or flush,
// reads return one cycle after acceptance, and a same-cycle write to the
// read set is forwarded. Optional feature macro: LRU_PARITY_EN (stores an
// even-parity bit per entry and reports mismatches on par_err).
module lru_state_array
  import lru_pkg::*;
#(
  parameter int NUM_SETS = 32,
  parameter int SET_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  output logic             ready,
  input  logic             rd_req,
  input  logic [SET_W-1:0] rd_set,
  output logic             rd_ack,
  output logic [LRU_W-1:0] rd_lru,
  output logic [VLD_W-1:0] rd_vld,
  input  logic             wr_req,
  input  logic [SET_W-1:0] wr_set,
  input  logic [LRU_W-1:0] wr_lru,
  input  logic [VLD_W-1:0] wr_vld
`ifdef LRU_PARITY_EN
  ,
  output logic             par_err
`endif
);

  // One extra counter bit so the terminal compare can never alias on wrap.
  localparam logic [SET_W:0] LAST_SET = (SET_W + 1)'(NUM_SETS - 1);

  logic [0:0]         state_q, state_d;
  logic [SET_W:0]     init_cnt_q, init_cnt_d;
  logic               in_run;
  logic               init_last;
  logic               rd_acc;
  logic               wr_acc;
  logic               fwd;

  logic               ram_we;
  logic [SET_W-1:0]   ram_waddr;
  logic [ENTRY_W-1:0] ram_wdata;
  logic [ENTRY_W-1:0] ram_rdata;

  logic               rd_ack_q;
  logic [LRU_W-1:0]   rd_lru_q, rd_lru_d;
  logic [VLD_W-1:0]   rd_vld_q, rd_vld_d;
  lru_entry_t         wr_ent;
  lru_entry_t         init_ent;

  assign in_run    = (state_q == RUN);
  assign init_last = (init_cnt_q == LAST_SET);

  // A request issued alongside flush is dropped, as is anything during INIT.
  assign rd_acc = in_run & rd_req & ~flush;
  assign wr_acc = in_run & wr_req & ~flush;
  assign fwd    = wr_acc & (wr_set == rd_set);

  assign wr_ent   = '{vld: wr_vld, lru: wr_lru};
  assign init_ent = '{vld: VLD_INIT, lru: LRU_INIT};

  // Next-state logic: flush always restarts the walk; INIT steps through sets.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (flush) begin
      state_d    = INIT;
      init_cnt_d = '0;
    end else if (!in_run) begin
      if (init_last) begin
        state_d = RUN;
      end else begin
        init_cnt_d = init_cnt_q + 1'b1;
      end
    end
  end

  // FSM and walker registers; reset lands in the same state as a flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // RAM write port: the walker owns it during INIT, requests own it in RUN.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = wr_set;
`ifdef LRU_PARITY_EN
    ram_wdata = {lru_parity(wr_ent), wr_ent};
`else
    ram_wdata = wr_ent;
`endif
    if (!in_run) begin
      ram_we    = 1'b1;
      ram_waddr = init_cnt_q[SET_W-1:0];
`ifdef LRU_PARITY_EN
      ram_wdata = {1'b0, init_ent};
`else
      ram_wdata = init_ent;
`endif
    end else if (wr_acc) begin
      ram_we = 1'b1;
    end
  end

  lru_ram #(
    .NUM_SETS (NUM_SETS),
    .SET_W    (SET_W)
  ) u_ram (
    .clk      (clk),
    .we_i     (ram_we),
    .waddr_i  (ram_waddr),
    .wdata_i  (ram_wdata),
    .raddr_i  (rd_set),
    .rdata_o  (ram_rdata)
  );

  // Read mux: write-first forwarding when both ports hit the same set.
  always_comb begin
    rd_lru_d = ram_rdata[LRU_W-1:0];
    rd_vld_d = ram_rdata[LRU_W+VLD_W-1:LRU_W];
    if (fwd) begin
      rd_lru_d = wr_lru;
      rd_vld_d = wr_vld;
    end
  end

  // Output registers: data only updates on an accepted read, ack is a pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ack_q <= 1'b0;
      rd_lru_q <= LRU_INIT;
      rd_vld_q <= VLD_INIT;
    end else begin
      rd_ack_q <= rd_acc;
      if (rd_acc) begin
        rd_lru_q <= rd_lru_d;
        rd_vld_q <= rd_vld_d;
      end
    end
  end

`ifdef LRU_PARITY_EN
  logic par_err_q;

  // Parity flag: forwarded data is freshly generated, so it is never flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= rd_acc & ~fwd & (^ram_rdata);
    end
  end

  assign par_err = par_err_q;
`endif

  assign ready  = in_run;
  assign rd_ack = rd_ack_q;
  assign rd_lru = rd_lru_q;
  assign rd_vld = rd_vld_q;

endmodule

// File: tb/tb_lru_state_array.sv
// tb_lru_state_array: scoreboard bench for lru_state_array. Expected read
// results come from a per-set model and are queued when a read is issued,
// then popped when rd_ack appears. Parity checks compile with LRU_PARITY_EN.
module tb_lru_state_array;

  localparam int NUM_SETS = 32;
  localparam int SET_W    = 5;

  typedef struct packed {
    logic       rd;
    logic [4:0] rs;
    logic       wr;
    logic [4:0] ws;
    logic [8:0] wl;
    logic [2:0] wv;
  } op_t;

  typedef struct packed {
    logic [8:0] lru;
    logic [2:0] vld;
    logic       perr;
    int         due;
  } exp_t;

  localparam op_t IDLE = '0;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       ready;
  logic       rd_req;
  logic [4:0] rd_set;
  logic       rd_ack;
  logic [8:0] rd_lru;
  logic [2:0] rd_vld;
  logic       wr_req;
  logic [4:0] wr_set;
  logic [8:0] wr_lru;
  logic [2:0] wr_vld;
  logic       perr_w;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  exp_t sb_q[$];
  op_t  ops[$];

  logic [8:0] m_lru [NUM_SETS];
  logic [2:0] m_vld [NUM_SETS];
  logic       m_bad [NUM_SETS];

`ifdef LRU_PARITY_EN
  logic par_err;
  assign perr_w = par_err;
`else
  assign perr_w = 1'b0;
`endif

  lru_state_array #(
    .NUM_SETS (NUM_SETS),
    .SET_W    (SET_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .ready  (ready),
    .rd_req (rd_req),
    .rd_set (rd_set),
    .rd_ack (rd_ack),
    .rd_lru (rd_lru),
    .rd_vld (rd_vld),
    .wr_req (wr_req),
    .wr_set (wr_set),
    .wr_lru (wr_lru),
    .wr_vld (wr_vld)
`ifdef LRU_PARITY_EN
    ,
    .par_err(par_err)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic op_t mk(input logic rd, input logic [4:0] rs, input logic wr,
                             input logic [4:0] ws, input logic [8:0] wl, input logic [2:0] wv);
    op_t o;
    o.rd = rd; o.rs = rs; o.wr = wr; o.ws = ws; o.wl = wl; o.wv = wv;
    return o;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NUM_SETS; i++) begin
      m_lru[i] = 9'h000;
      m_vld[i] = 3'b000;
      m_bad[i] = 1'b0;
    end
  endtask

  // Drive one cycle of stimulus (called just after a falling edge) and queue
  // the expected result of any read the design will accept.
  task automatic issue(input op_t op, input logic fl);
    exp_t e;
    rd_req = op.rd; rd_set = op.rs;
    wr_req = op.wr; wr_set = op.ws; wr_lru = op.wl; wr_vld = op.wv;
    flush  = fl;
    if (fl) begin
      model_clear();
    end else if (ready) begin
      if (op.rd) begin
        if (op.wr && op.ws == op.rs) begin
          e.lru = op.wl; e.vld = op.wv; e.perr = 1'b0;
        end else begin
          e.lru = m_lru[op.rs]; e.vld = m_vld[op.rs]; e.perr = m_bad[op.rs];
        end
        e.due = cyc + 1;
        sb_q.push_back(e);
      end
      if (op.wr) begin
        m_lru[op.ws] = op.wl;
        m_vld[op.ws] = op.wv;
        m_bad[op.ws] = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    exp_t e;
    int   cnt;
    rst = 1'b1;
    issue(IDLE, 1'b0);
    model_clear();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (ready !== 1'b0 || rd_ack !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: ready=%b rd_ack=%b, want 0 0", ready, rd_ack);
    end
    n_cmp++;
    if (rd_lru !== 9'h000 || rd_vld !== 3'b000 || perr_w !== 1'b0) begin
      n_err++;
      $display("FAIL reset_data: lru=%h vld=%b perr=%b, want 000 000 0", rd_lru, rd_vld, perr_w);
    end
    rst = 1'b0;
    cnt = 0;
    while (!ready && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    n_cmp++;
    if (cnt != 32) begin
      n_err++;
      $display("FAIL reset_init_len: ready low %0d cycles, want 32", cnt);
    end
    ops.delete();
    ops.push_back(mk(1, 17, 0, 0, 9'h000, 3'b000));
    for (int k = 0; k < ops.size() + 3; k++) begin
      @(negedge clk);
      if (rd_ack) begin
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL reset_read: unexpected rd_ack at cycle %0d, want none", cyc);
        end else begin
          e = sb_q.pop_front();
          if (rd_lru !== e.lru || rd_vld !== e.vld || perr_w !== e.perr || cyc != e.due) begin
            n_err++;
            $display("FAIL reset_read: lru=%h vld=%b perr=%b cyc=%0d, want %h %b %b cyc=%0d",
                     rd_lru, rd_vld, perr_w, cyc, e.lru, e.vld, e.perr, e.due);
          end
        end
      end
      issue((k < ops.size()) ? ops[k] : IDLE, 1'b0);
    end
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL reset_read_missing: %0d reads unacked, want 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_write_read();
    exp_t e;
    ops.delete();
    ops.push_back(mk(0, 0, 1, 5, 9'h1A3, 3'b101));
    ops.push_back(mk(1, 5, 0, 0, 9'h000, 3'b000));
    ops.push_back(mk(1, 6, 0, 0, 9'h000, 3'b000));
    for (int k = 0; k < ops.size() + 3; k++) begin
      @(negedge clk);
      if (rd_ack) begin
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL write_read: unexpected rd_ack at cycle %0d, want none", cyc);
        end else begin
          e = sb_q.pop_front();
          if (rd_lru !== e.lru || rd_vld !== e.vld || perr_w !== e.perr || cyc != e.due) begin
            n_err++;
            $display("FAIL write_read: lru=%h vld=%b perr=%b cyc=%0d, want %h %b %b cyc=%0d",
                     rd_lru, rd_vld, perr_w, cyc, e.lru, e.vld, e.perr, e.due);
          end
        end
      end
      issue((k < ops.size()) ? ops[k] : IDLE, 1'b0);
    end
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL write_read_missing: %0d reads unacked, want 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_forward();
    exp_t e;
    ops.delete();
    ops.push_back(mk(1, 9, 1, 9, 9'h0F0, 3'b010));
    ops.push_back(mk(0, 0, 0, 0, 9'h000, 3'b000));
    ops.push_back(mk(1, 9, 0, 0, 9'h000, 3'b000));
    ops.push_back(mk(0, 0, 0, 0, 9'h000, 3'b000));
    ops.push_back(mk(1, 5, 1, 10, 9'h12C, 3'b011));
    ops.push_back(mk(0, 0, 0, 0, 9'h000, 3'b000));
    ops.push_back(mk(1, 10, 0, 0, 9'h000, 3'b000));
    for (int k = 0; k < ops.size() + 3; k++) begin
      @(negedge clk);
      if (rd_ack) begin
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL forward: unexpected rd_ack at cycle %0d, want none", cyc);
        end else begin
          e = sb_q.pop_front();
          if (rd_lru !== e.lru || rd_vld !== e.vld || perr_w !== e.perr || cyc != e.due) begin
            n_err++;
            $display("FAIL forward: lru=%h vld=%b perr=%b cyc=%0d, want %h %b %b cyc=%0d",
                     rd_lru, rd_vld, perr_w, cyc, e.lru, e.vld, e.perr, e.due);
          end
        end
      end
      issue((k < ops.size()) ? ops[k] : IDLE, 1'b0);
    end
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL forward_missing: %0d reads unacked, want 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    ops.delete();
    ops.push_back(mk(0, 0, 1, 20, 9'h111, 3'b001));
    ops.push_back(mk(1, 20, 1, 21, 9'h0AB, 3'b010));
    ops.push_back(mk(1, 21, 0, 0, 9'h000, 3'b000));
    ops.push_back(mk(1, 20, 1, 20, 9'h18C, 3'b100));
    ops.push_back(mk(1, 20, 0, 0, 9'h000, 3'b000));
    ops.push_back(mk(1, 5, 0, 0, 9'h000, 3'b000));
    ops.push_back(mk(1, 9, 1, 12, 9'h07E, 3'b111));
    ops.push_back(mk(1, 12, 0, 0, 9'h000, 3'b000));
    for (int k = 0; k < ops.size() + 3; k++) begin
      @(negedge clk);
      if (rd_ack) begin
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL back_to_back: unexpected rd_ack at cycle %0d, want none", cyc);
        end else begin
          e = sb_q.pop_front();
          if (rd_lru !== e.lru || rd_vld !== e.vld || perr_w !== e.perr || cyc != e.due) begin
            n_err++;
            $display("FAIL back_to_back: lru=%h vld=%b perr=%b cyc=%0d, want %h %b %b cyc=%0d",
                     rd_lru, rd_vld, perr_w, cyc, e.lru, e.vld, e.perr, e.due);
          end
        end
      end
      issue((k < ops.size()) ? ops[k] : IDLE, 1'b0);
    end
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL back_to_back_missing: %0d reads unacked, want 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_flush();
    exp_t e;
    int   cnt;
    ops.delete();
    ops.push_back(mk(0, 0, 1, 0, 9'h1FF, 3'b111));
    ops.push_back(mk(0, 0, 1, 31, 9'h1FF, 3'b111));
    for (int k = 0; k < ops.size(); k++) begin
      @(negedge clk);
      issue(ops[k], 1'b0);
    end
    // Flush together with a read and a write: both must be dropped.
    @(negedge clk);
    issue(mk(1, 0, 1, 1, 9'h0AA, 3'b010), 1'b1);
    @(negedge clk);
    issue(IDLE, 1'b0);
    n_cmp++;
    if (rd_ack !== 1'b0 || ready !== 1'b0) begin
      n_err++;
      $display("FAIL flush_drop: rd_ack=%b ready=%b, want 0 0", rd_ack, ready);
    end
    cnt = 0;
    while (!ready && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    n_cmp++;
    if (cnt != 32) begin
      n_err++;
      $display("FAIL flush_init_len: ready low %0d cycles, want 32", cnt);
    end
    ops.delete();
    ops.push_back(mk(1, 0, 0, 0, 9'h000, 3'b000));
    ops.push_back(mk(1, 31, 0, 0, 9'h000, 3'b000));
    ops.push_back(mk(1, 1, 0, 0, 9'h000, 3'b000));
    for (int k = 0; k < ops.size() + 3; k++) begin
      if (k > 0) @(negedge clk);
      if (rd_ack) begin
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL flush_read: unexpected rd_ack at cycle %0d, want none", cyc);
        end else begin
          e = sb_q.pop_front();
          if (rd_lru !== e.lru || rd_vld !== e.vld || perr_w !== e.perr || cyc != e.due) begin
            n_err++;
            $display("FAIL flush_read: lru=%h vld=%b perr=%b cyc=%0d, want %h %b %b cyc=%0d",
                     rd_lru, rd_vld, perr_w, cyc, e.lru, e.vld, e.perr, e.due);
          end
        end
      end
      issue((k < ops.size()) ? ops[k] : IDLE, 1'b0);
    end
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL flush_read_missing: %0d reads unacked, want 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_init_ignore();
    exp_t e;
    int   cnt;
    int   acks;
    acks = 0;
    @(negedge clk);
    issue(IDLE, 1'b1);
    @(negedge clk);
    issue(IDLE, 1'b0);
    // Requests while initialising must produce neither an ack nor a write.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rd_ack) acks++;
      issue(mk(1, 3, 1, 3, 9'h055, 3'b101), 1'b0);
    end
    // Flush mid-walk restarts the count from set 0.
    @(negedge clk);
    if (rd_ack) acks++;
    issue(IDLE, 1'b1);
    @(negedge clk);
    if (rd_ack) acks++;
    issue(IDLE, 1'b0);
    cnt = 0;
    while (!ready && cnt < 100) begin
      cnt++;
      if (rd_ack) acks++;
      @(negedge clk);
    end
    n_cmp++;
    if (cnt != 32) begin
      n_err++;
      $display("FAIL init_restart_len: ready low %0d cycles, want 32", cnt);
    end
    n_cmp++;
    if (acks != 0) begin
      n_err++;
      $display("FAIL init_no_ack: %0d acks during INIT, want 0", acks);
    end
    ops.delete();
    ops.push_back(mk(1, 3, 0, 0, 9'h000, 3'b000));
    for (int k = 0; k < ops.size() + 3; k++) begin
      if (k > 0) @(negedge clk);
      if (rd_ack) begin
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL init_read: unexpected rd_ack at cycle %0d, want none", cyc);
        end else begin
          e = sb_q.pop_front();
          if (rd_lru !== e.lru || rd_vld !== e.vld || perr_w !== e.perr || cyc != e.due) begin
            n_err++;
            $display("FAIL init_read: lru=%h vld=%b perr=%b cyc=%0d, want %h %b %b cyc=%0d",
                     rd_lru, rd_vld, perr_w, cyc, e.lru, e.vld, e.perr, e.due);
          end
        end
      end
      issue((k < ops.size()) ? ops[k] : IDLE, 1'b0);
    end
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL init_read_missing: %0d reads unacked, want 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    int   cnt;
    @(negedge clk);
    issue(mk(0, 0, 1, 7, 9'h155, 3'b110), 1'b0);
    @(negedge clk);
    issue(IDLE, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (ready !== 1'b0 || rd_ack !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: ready=%b rd_ack=%b right after rst, want 0 0", ready, rd_ack);
    end
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    while (!ready && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    n_cmp++;
    if (cnt != 32) begin
      n_err++;
      $display("FAIL async_reset_len: ready low %0d cycles, want 32", cnt);
    end
    ops.delete();
    ops.push_back(mk(1, 7, 0, 0, 9'h000, 3'b000));
    for (int k = 0; k < ops.size() + 3; k++) begin
      if (k > 0) @(negedge clk);
      if (rd_ack) begin
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL async_reset_read: unexpected rd_ack at cycle %0d, want none", cyc);
        end else begin
          e = sb_q.pop_front();
          if (rd_lru !== e.lru || rd_vld !== e.vld || perr_w !== e.perr || cyc != e.due) begin
            n_err++;
            $display("FAIL async_reset_read: lru=%h vld=%b perr=%b cyc=%0d, want %h %b %b cyc=%0d",
                     rd_lru, rd_vld, perr_w, cyc, e.lru, e.vld, e.perr, e.due);
          end
        end
      end
      issue((k < ops.size()) ? ops[k] : IDLE, 1'b0);
    end
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL async_reset_read_missing: %0d reads unacked, want 0", sb_q.size());
      sb_q.delete();
    end
  endtask

`ifdef LRU_PARITY_EN
  task automatic test_parity();
    exp_t e;
    @(negedge clk);
    issue(mk(0, 0, 1, 2, 9'h0C3, 3'b011), 1'b0);
    @(negedge clk);
    issue(IDLE, 1'b0);
    // Corrupt one stored LRU bit behind the design's back.
    dut.u_ram.mem_q[2][4] = ~dut.u_ram.mem_q[2][4];
    m_lru[2] = m_lru[2] ^ 9'h010;
    m_bad[2] = 1'b1;
    ops.delete();
    ops.push_back(mk(1, 2, 0, 0, 9'h000, 3'b000));
    ops.push_back(mk(1, 3, 0, 0, 9'h000, 3'b000));
    ops.push_back(mk(1, 2, 1, 2, 9'h101, 3'b001));
    ops.push_back(mk(1, 2, 0, 0, 9'h000, 3'b000));
    for (int k = 0; k < ops.size() + 3; k++) begin
      @(negedge clk);
      if (rd_ack) begin
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL parity: unexpected rd_ack at cycle %0d, want none", cyc);
        end else begin
          e = sb_q.pop_front();
          if (rd_lru !== e.lru || rd_vld !== e.vld || perr_w !== e.perr || cyc != e.due) begin
            n_err++;
            $display("FAIL parity: lru=%h vld=%b perr=%b cyc=%0d, want %h %b %b cyc=%0d",
                     rd_lru, rd_vld, perr_w, cyc, e.lru, e.vld, e.perr, e.due);
          end
        end
      end
      issue((k < ops.size()) ? ops[k] : IDLE, 1'b0);
    end
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL parity_missing: %0d reads unacked, want 0", sb_q.size());
      sb_q.delete();
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_forward();
    test_back_to_back();
    test_flush();
    test_init_ignore();
    test_async_reset();
`ifdef LRU_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
